// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte FIFO feeding a
// registered serializer that sends each byte LSB first.
module uart_tx_fifo #(
   parameter int CLK_PER_BIT = 868,
   parameter int DEPTH_LOG2  = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  UART_TX,
   output logic                  tx_busy,
   output logic [DEPTH_LOG2:0]   fifo_cnt
);

   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam int BW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_PER_BIT - 1);
   localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_e;

   state_e                state_q, state_d;
   logic [7:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_q, wr_d;
   logic [DEPTH_LOG2-1:0] rd_q, rd_d;
   logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
   logic [BW-1:0]         baud_q, baud_d;
   logic [2:0]            bit_q, bit_d;
   logic [7:0]            sh_q, sh_d;
   logic                  tx_q, tx_d;
   logic                  push, pop, baud_end;

   assign in_ready = !RST && (cnt_q != FULL);
   assign push     = in_valid && in_ready;
   assign baud_end = (baud_q == BAUD_LAST);

   assign UART_TX  = tx_q;
   assign tx_busy  = (state_q != S_IDLE);
   assign fifo_cnt = cnt_q;

   // Line level follows the current state one cycle later.
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      bit_d   = bit_q;
      baud_d  = baud_q + 1'b1;
      pop     = 1'b0;
      tx_d    = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            baud_d = '0;
            if (cnt_q != '0) begin
               pop     = 1'b1;
               sh_d    = mem_q[rd_q];
               state_d = S_START;
            end
         end
         S_START: begin
            tx_d = 1'b0;
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            tx_d = sh_q[0];
            if (baud_end) begin
               baud_d = '0;
               sh_d   = {1'b0, sh_q[7:1]};
               bit_d  = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         baud_q  <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         tx_q    <= tx_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_q] <= in_data;
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: byte scoreboard fed by an independent
// serial-line receiver model, plus cycle-exact frame timing checks.
module tb_uart_tx_fifo;

   localparam int CPB = 4;
   localparam int DL2 = 2;
   localparam int DEPTH = 2**DL2;

   logic         clk;
   logic         rst;
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_ready;
   logic         uart_tx;
   logic         tx_busy;
   logic [DL2:0] fifo_cnt;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   int         gap_q[$];
   int         frame_err;
   int         hi_run;
   int         mon_t;
   bit         mon_busy;
   logic [7:0] mon_sh;

   uart_tx_fifo #(
      .CLK_PER_BIT (CPB),
      .DEPTH_LOG2  (DL2)
   ) dut (
      .CLK      (clk),
      .RST      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .UART_TX  (uart_tx),
      .tx_busy  (tx_busy),
      .fifo_cnt (fifo_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #(10 * 60000);
      $display("FAIL watchdog: simulation still running, required done");
      $fatal(1, "watchdog expired");
   end

   // Receiver model: samples mid-bit, records idle-high run before each start.
   initial begin
      int bi;
      mon_busy  = 1'b0;
      hi_run    = 0;
      frame_err = 0;
      mon_t     = 0;
      mon_sh    = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mon_busy = 1'b0;
            hi_run   = 0;
         end else if (!mon_busy) begin
            if (uart_tx === 1'b1) begin
               hi_run++;
            end else begin
               gap_q.push_back(hi_run);
               hi_run   = 0;
               mon_busy = 1'b1;
               mon_t    = 0;
            end
         end else begin
            mon_t++;
            if (mon_t == CPB/2 && uart_tx !== 1'b0) frame_err++;
            if (mon_t >= CPB && mon_t < 9*CPB && (mon_t % CPB) == CPB/2) begin
               bi = mon_t / CPB - 1;
               mon_sh[bi[2:0]] = uart_tx;
            end
            if (mon_t == 9*CPB + CPB/2) begin
               if (uart_tx === 1'b1) rx_q.push_back(mon_sh);
               else frame_err++;
               mon_busy = 1'b0;
               hi_run   = CPB/2 + 1;
            end
         end
      end
   end

   function automatic logic line_model(input int k, input logic [7:0] b);
      int j;
      j = k - 2;
      if (j < 0 || j >= 10*CPB) return 1'b1;
      if (j / CPB == 0) return 1'b0;
      if (j / CPB == 9) return 1'b1;
      return b[j / CPB - 1];
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clear();
      exp_q.delete();
      rx_q.delete();
      gap_q.delete();
   endtask

   task automatic push_byte(input logic [7:0] b);
      int n;
      n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 2000) begin
         step();
         n++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
      end else begin
         exp_q.push_back(b);
      end
      step();
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic drain();
      int n;
      bit ok;
      n  = 0;
      ok = 1'b0;
      while (n < 3000) begin
         if (fifo_cnt == 0 && !tx_busy && !mon_busy) begin
            ok = 1'b1;
            break;
         end
         step();
         n++;
      end
      if (!ok) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: fifo_cnt=%0d tx_busy=%b required 0/0",
                  fifo_cnt, tx_busy);
      end
      repeat (2) step();
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hAA;
      step();
      step();
      n_cmp += 4;
      if (in_ready !== 1'b0) begin
         n_err++; $display("FAIL rst_ready: got %b required 0", in_ready);
      end
      if (uart_tx !== 1'b1) begin
         n_err++; $display("FAIL rst_line: got %b required 1", uart_tx);
      end
      if (tx_busy !== 1'b0) begin
         n_err++; $display("FAIL rst_busy: got %b required 0", tx_busy);
      end
      if (fifo_cnt !== 0) begin
         n_err++; $display("FAIL rst_cnt: got %0d required 0", fifo_cnt);
      end
      in_valid = 1'b0;
      rst      = 1'b0;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL post_rst_ready: got %b required 1", in_ready);
      end
      repeat (3) step();
      n_cmp++;
      if (uart_tx !== 1'b1 || fifo_cnt !== 0) begin
         n_err++;
         $display("FAIL post_rst_idle: line=%b cnt=%0d required 1/0", uart_tx, fifo_cnt);
      end
   endtask

   task automatic test_single(input logic [7:0] b);
      logic exp_l;
      logic exp_b;
      clear();
      push_byte(b);
      n_cmp += 2;
      if (fifo_cnt !== 1) begin
         n_err++; $display("FAIL t1_cnt_push: got %0d required 1", fifo_cnt);
      end
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin
         n_err++;
         $display("FAIL t1_k0: line=%b busy=%b required 1/0", uart_tx, tx_busy);
      end
      for (int k = 1; k <= 10*CPB + 5; k++) begin
         step();
         exp_l = line_model(k, b);
         exp_b = (k >= 1 && k <= 10*CPB);
         n_cmp += 2;
         if (uart_tx !== exp_l) begin
            n_err++;
            $display("FAIL t1_line k=%0d byte=%h: got %b required %b", k, b, uart_tx, exp_l);
         end
         if (tx_busy !== exp_b) begin
            n_err++;
            $display("FAIL t1_busy k=%0d: got %b required %b", k, tx_busy, exp_b);
         end
         if (k == 1) begin
            n_cmp++;
            if (fifo_cnt !== 0) begin
               n_err++; $display("FAIL t1_cnt_pop: got %0d required 0", fifo_cnt);
            end
         end
      end
      drain();
      n_cmp++;
      if (rx_q.size() != 1 || rx_q[0] !== b) begin
         n_err++;
         $display("FAIL t1_decode: got %0d frames first=%h required 1 frame %h",
                  rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00, b);
      end
   endtask

   task automatic test_back_to_back();
      int peak;
      clear();
      peak = 0;
      push_byte(8'hA3);
      if (int'(fifo_cnt) > peak) peak = int'(fifo_cnt);
      push_byte(8'h00);
      if (int'(fifo_cnt) > peak) peak = int'(fifo_cnt);
      push_byte(8'hFF);
      for (int i = 0; i < 30; i++) begin
         if (int'(fifo_cnt) > peak) peak = int'(fifo_cnt);
         step();
      end
      drain();
      n_cmp++;
      if (peak != 2) begin
         n_err++; $display("FAIL t2_peak: got %0d required 2", peak);
      end
      n_cmp++;
      if (rx_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL t2_frames: got %0d required %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         n_cmp++;
         if (rx_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL t2_byte%0d: got %h required %h", i, rx_q[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (gap_q.size() != 3) begin
         n_err++; $display("FAIL t2_starts: got %0d required 3", gap_q.size());
      end
      for (int i = 1; i < gap_q.size(); i++) begin
         n_cmp++;
         if (gap_q[i] != CPB + 1) begin
            n_err++; $display("FAIL t2_stop%0d: got %0d required %0d", i, gap_q[i], CPB + 1);
         end
      end
   endtask

   task automatic test_full();
      int acc;
      clear();
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         in_data  = 8'($urandom);
         in_valid = 1'b1;
         if (in_ready) begin
            exp_q.push_back(in_data);
            acc++;
         end
         step();
      end
      in_valid = 1'b0;
      #1;
      n_cmp += 3;
      if (acc != DEPTH + 1) begin
         n_err++; $display("FAIL t3_accepted: got %0d required %0d", acc, DEPTH + 1);
      end
      if (fifo_cnt !== DEPTH) begin
         n_err++; $display("FAIL t3_cnt: got %0d required %0d", fifo_cnt, DEPTH);
      end
      if (in_ready !== 1'b0) begin
         n_err++; $display("FAIL t3_ready: got %b required 0", in_ready);
      end
      for (int i = 0; i < 4; i++) push_byte(8'($urandom));
      drain();
      n_cmp++;
      if (rx_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL t3_frames: got %0d required %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         n_cmp++;
         if (rx_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL t3_byte%0d: got %h required %h", i, rx_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int lows;
      clear();
      push_byte(8'h3C);
      for (int i = 0; i < 3; i++) push_byte(8'($urandom));
      repeat (10) step();
      n_cmp++;
      if (tx_busy !== 1'b1 || fifo_cnt !== 3) begin
         n_err++;
         $display("FAIL t4_pre: busy=%b cnt=%0d required 1/3", tx_busy, fifo_cnt);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++;
      if (uart_tx !== 1'b1 || fifo_cnt !== 0 || tx_busy !== 1'b0) begin
         n_err++;
         $display("FAIL t4_reset: line=%b cnt=%0d busy=%b required 1/0/0",
                  uart_tx, fifo_cnt, tx_busy);
      end
      lows = 0;
      for (int i = 0; i < 12*CPB; i++) begin
         step();
         if (uart_tx !== 1'b1) lows++;
      end
      n_cmp += 2;
      if (lows != 0) begin
         n_err++; $display("FAIL t4_quiet: got %0d low cycles required 0", lows);
      end
      if (rx_q.size() != 0) begin
         n_err++; $display("FAIL t4_dropped: got %0d frames required 0", rx_q.size());
      end
      exp_q.delete();
      push_byte(8'h81);
      drain();
      n_cmp++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'h81) begin
         n_err++;
         $display("FAIL t4_after: got %0d frames first=%h required 1 frame 81",
                  rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00);
      end
   endtask

   task automatic test_push_on_pop();
      logic [7:0] a;
      logic [7:0] b;
      clear();
      a = 8'($urandom);
      b = 8'($urandom);
      push_byte(a);
      push_byte(b);
      n_cmp++;
      if (fifo_cnt !== 1 || tx_busy !== 1'b1) begin
         n_err++;
         $display("FAIL t5_cnt: cnt=%0d busy=%b required 1/1", fifo_cnt, tx_busy);
      end
      drain();
      n_cmp++;
      if (rx_q.size() != 2 || rx_q[0] !== a || rx_q[1] !== b) begin
         n_err++;
         $display("FAIL t5_order: got %0d frames required %h,%h", rx_q.size(), a, b);
      end
   endtask

   task automatic test_stream(input bit rand_data, input int nbytes);
      clear();
      for (int i = 0; i < nbytes; i++) begin
         repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            step();
         end
         push_byte(rand_data ? 8'($urandom) : 8'(i));
      end
      drain();
      n_cmp++;
      if (rx_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL stream_frames: got %0d required %0d", rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         n_cmp++;
         if (rx_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL stream_byte%0d: got %h required %h", i, rx_q[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (frame_err != 0) begin
         n_err++; $display("FAIL framing: got %0d bad frames required 0", frame_err);
      end
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      test_reset();
      test_single(8'h55);
      test_single(8'($urandom));
      test_back_to_back();
      test_full();
      test_reset_mid();
      test_push_on_pop();
      test_stream(1'b0, 40);
      test_stream(1'b1, 16);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
